// File: rtl/iic_arb_pkg.sv
// Shared types for the IIC bus arbiter: FSM state encoding and width helpers.
package iic_arb_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } arb_state_e;

    // Index width for n clients, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iic_bus_arbiter_if.sv
// Client-side request bundle plus IIC master command/result signals.
// master: arbiter view. slave: clients and IIC master engine view.
interface iic_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8
) ();
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         rdata;
    logic                      wr_en;
    logic                      rd_en;
    logic                      iic_start;
    logic [ADDR_W-1:0]         byte_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      iic_end;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        input  req, req_rd, req_addr, req_wdata, iic_end, rd_data,
        output gnt, done, err, rdata, wr_en, rd_en, iic_start, byte_addr, wr_data
    );

    modport slave (
        output req, req_rd, req_addr, req_wdata, iic_end, rd_data,
        input  gnt, done, err, rdata, wr_en, rd_en, iic_start, byte_addr, wr_data
    );
endinterface

// File: rtl/iic_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
module iic_rr_pick
    import iic_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_valid_c
);

    // Client index k positions above the pointer, modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from the pointer and keep the first hit.
    always_comb begin
        o_pick_c  = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_valid_c && i_req[rot(i_ptr, k)]) begin
                o_pick_c[rot(i_ptr, k)] = 1'b1;
                o_idx_c                 = rot(i_ptr, k);
                o_valid_c               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one IIC master among NUM_REQ clients,
// one transaction per grant. Optional watchdog: define IIC_ARB_TIMEOUT_EN.
module iic_bus_arbiter
    import iic_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    iic_bus_arbiter_if.master    bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("iic_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("iic_bus_arbiter: TIMEOUT_CYC must be at least 2");
    end

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_owner;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                r_start;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [NUM_REQ-1:0]  w_pick;
    logic [IDX_W-1:0]    w_idx;
    logic                w_valid;

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     r_wd;
    logic [NUM_REQ-1:0]  r_err;
`endif

    iic_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req     (bus.req),
        .i_ptr     (r_ptr),
        .o_pick_c  (w_pick),
        .o_idx_c   (w_idx),
        .o_valid_c (w_valid)
    );

    // Arbitration FSM with registered grant, command and result outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            r_wd    <= '0;
            r_err   <= '0;
`endif
        end else begin
            r_done  <= '0;
            r_start <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            r_err   <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_idx;
                        r_gnt   <= w_pick;
                        r_addr  <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_wdata <= bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_wr_en <= ~bus.req_rd[w_idx];
                        r_rd_en <= bus.req_rd[w_idx];
                        r_state <= LATCH;
                    end
                end
                LATCH: begin
                    r_start <= 1'b1;
                    r_state <= START;
                end
                START: begin
`ifdef IIC_ARB_TIMEOUT_EN
                    r_wd    <= WD_W'(1);
`endif
                    r_state <= BUSY;
                end
                BUSY: begin
                    if (bus.iic_end) begin
                        r_rdata <= bus.rd_data;
                        r_done  <= r_gnt;
                        r_state <= DONE;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    // r_wd counts clocks since START; DONE lands TIMEOUT_CYC clocks after it.
                    else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_rdata <= '0;
                        r_done  <= r_gnt;
                        r_err   <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    r_gnt   <= '0;
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_ptr   <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.wr_en     = r_wr_en;
    assign bus.rd_en     = r_rd_en;
    assign bus.iic_start = r_start;
    assign bus.byte_addr = r_addr;
    assign bus.wr_data   = r_wdata;
`ifdef IIC_ARB_TIMEOUT_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = '0;
`endif

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed testbench for iic_bus_arbiter (2 clients, 16-bit address, 8-bit data).
module tb_iic_bus_arbiter;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    iic_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iic_bus_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int c, input bit rd, input logic [15:0] a, input logic [7:0] d);
        bus.req_rd[c]                         = rd;
        bus.req_addr[c*ADDR_W +: ADDR_W]      = a;
        bus.req_wdata[c*DATA_W +: DATA_W]     = d;
    endtask

    task automatic end_pulse(input logic [7:0] d);
        bus.iic_end = 1'b1;
        bus.rd_data = d;
        tick();
        bus.iic_end = 1'b0;
    endtask

    // One full transaction under held requests; ends on the done cycle.
    task automatic run_txn(input string tag, input logic [1:0] exp_gnt,
                           input logic [15:0] exp_addr, input logic [7:0] rdv);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.gnt != '0) begin ok = 1'b1; break; end
        end
        check({tag, "_gnt_seen"}, 32'(ok), 32'd1);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check({tag, "_addr"}, 32'(bus.byte_addr), 32'(exp_addr));
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.iic_start) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, "_start_seen"}, 32'(ok), 32'd1);
        tick();
        end_pulse(rdv);
        check({tag, "_done"}, 32'(bus.done), 32'(exp_gnt));
        check({tag, "_done_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        check({tag, "_rdata"}, 32'(bus.rdata), 32'(rdv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req       = '0;
        bus.req_rd    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.iic_end   = 1'b0;
        bus.rd_data   = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_gnt",   32'(bus.gnt),       32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_err",   32'(bus.err),       32'd0);
        check("rst_wr_en", 32'(bus.wr_en),     32'd0);
        check("rst_rd_en", 32'(bus.rd_en),     32'd0);
        check("rst_start", 32'(bus.iic_start), 32'd0);
        check("rst_rdata", 32'(bus.rdata),     32'd0);

        // Single write from client 0
        set_client(0, 1'b0, 16'h0002, 8'h10);
        bus.req = 2'b01;
        tick();
        check("wr_latch_gnt",   32'(bus.gnt),       32'h1);
        check("wr_latch_start", 32'(bus.iic_start), 32'd0);
        check("wr_wr_en",       32'(bus.wr_en),     32'd1);
        check("wr_rd_en",       32'(bus.rd_en),     32'd0);
        check("wr_addr",        32'(bus.byte_addr), 32'h0002);
        check("wr_data",        32'(bus.wr_data),   32'h10);
        tick();
        check("wr_start",       32'(bus.iic_start), 32'd1);
        tick();
        check("wr_start_drop",  32'(bus.iic_start), 32'd0);
        check("wr_busy_wr_en",  32'(bus.wr_en),     32'd1);
        end_pulse(8'h5A);
        check("wr_done",        32'(bus.done),      32'h1);
        check("wr_rdata",       32'(bus.rdata),     32'h5A);
        bus.req = 2'b00;
        tick();
        check("wr_done_drop",   32'(bus.done),      32'd0);
        check("wr_idle_gnt",    32'(bus.gnt),       32'd0);
        check("wr_idle_wr_en",  32'(bus.wr_en),     32'd0);

        // Single read from client 1
        set_client(1, 1'b1, 16'h0008, 8'h00);
        bus.req = 2'b10;
        tick();
        check("rd_gnt",         32'(bus.gnt),       32'h2);
        check("rd_rd_en",       32'(bus.rd_en),     32'd1);
        check("rd_wr_en",       32'(bus.wr_en),     32'd0);
        check("rd_addr",        32'(bus.byte_addr), 32'h0008);
        tick();
        check("rd_start",       32'(bus.iic_start), 32'd1);
        tick();
        end_pulse(8'h24);
        check("rd_done",        32'(bus.done),      32'h2);
        check("rd_rdata",       32'(bus.rdata),     32'h24);
        check("rd_err",         32'(bus.err),       32'd0);
        bus.req = 2'b00;
        tick();
        check("rd_done_drop",   32'(bus.done),      32'd0);
        check("rd_rdata_hold",  32'(bus.rdata),     32'h24);
        check("rd_idle_rd_en",  32'(bus.rd_en),     32'd0);

        // Contention: both clients held, served alternately starting at client 0
        set_client(0, 1'b0, 16'h0100, 8'hA0);
        set_client(1, 1'b1, 16'h0101, 8'h00);
        bus.req = 2'b11;
        run_txn("rr0", 2'b01, 16'h0100, 8'h41);
        run_txn("rr1", 2'b10, 16'h0101, 8'h42);
        run_txn("rr2", 2'b01, 16'h0100, 8'h43);
        run_txn("rr3", 2'b10, 16'h0101, 8'h44);
        bus.req = 2'b00;
        tick();

        // Spurious iic_end in IDLE, then in LATCH
        end_pulse(8'h77);
        check("sp_idle_done",   32'(bus.done),      32'd0);
        check("sp_idle_gnt",    32'(bus.gnt),       32'd0);
        check("sp_idle_rdata",  32'(bus.rdata),     32'h44);
        bus.req = 2'b01;
        tick();
        check("sp_latch_gnt",   32'(bus.gnt),       32'h1);
        bus.iic_end = 1'b1;
        bus.rd_data = 8'h88;
        tick();
        bus.iic_end = 1'b0;
        check("sp_start",       32'(bus.iic_start), 32'd1);
        check("sp_start_done",  32'(bus.done),      32'd0);
        tick();
        check("sp_busy_done",   32'(bus.done),      32'd0);
        tick();
        check("sp_busy2_done",  32'(bus.done),      32'd0);
        check("sp_busy2_gnt",   32'(bus.gnt),       32'h1);
        end_pulse(8'h99);
        check("sp_done",        32'(bus.done),      32'h1);
        check("sp_rdata",       32'(bus.rdata),     32'h99);
        bus.req = 2'b00;
        tick();

        // Reset while client 1 is in BUSY
        bus.req = 2'b10;
        tick();
        tick();
        tick();
        check("rb_busy_gnt",    32'(bus.gnt),       32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rb_gnt",         32'(bus.gnt),       32'd0);
        check("rb_rd_en",       32'(bus.rd_en),     32'd0);
        check("rb_start",       32'(bus.iic_start), 32'd0);
        check("rb_done",        32'(bus.done),      32'd0);
        check("rb_rdata",       32'(bus.rdata),     32'd0);
        check("rb_addr",        32'(bus.byte_addr), 32'd0);
        bus.req = 2'b11;
        tick();
        check("rb_next_gnt",    32'(bus.gnt),       32'h1);
        tick();
        tick();
        end_pulse(8'h05);
        check("rb_next_done",   32'(bus.done),      32'h1);
        bus.req = 2'b00;
        tick();

`ifdef IIC_ARB_TIMEOUT_EN
        // Watchdog: client 1 read with no iic_end
        begin
            bit ok;
            int cyc;
            bus.req = 2'b10;
            tick();
            tick();
            check("to_start",   32'(bus.iic_start), 32'd1);
            ok  = 1'b0;
            cyc = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                cyc++;
                if (bus.done != '0) begin ok = 1'b1; break; end
            end
            check("to_seen",    32'(ok),            32'd1);
            check("to_latency", 32'(cyc),           32'(TIMEOUT_CYC));
            check("to_done",    32'(bus.done),      32'h2);
            check("to_err",     32'(bus.err),       32'h2);
            check("to_rdata",   32'(bus.rdata),     32'd0);
            bus.req = 2'b01;
            tick();
            check("to_err_drop", 32'(bus.err),      32'd0);
            tick();
            check("to_next_gnt", 32'(bus.gnt),      32'h1);
            tick();
            tick();
            end_pulse(8'h31);
            check("to_next_done", 32'(bus.done),    32'h1);
            check("to_next_err",  32'(bus.err),     32'd0);
            bus.req = 2'b00;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
